dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port byte-addressed, big-endian data memory. Port 0 is the pipeline MEM stage; port 1 is the debug/loader port. The block grants one requester at a time using round-robin, checks alignment and range, and drives the memory strobes for exactly one cycle per access. It returns read data and a per-port Done/Err pulse.

---
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and sequencer in front of a single-port, byte-addressed,
// big-endian data memory. Each access runs IDLE -> ISSUE -> RESP (or IDLE -> RESP on error).
module dmem_arbiter #(
  parameter int MEM_BYTES = 65536,
  parameter int RR_INIT   = 0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req0,
  input  logic        Write0,
  input  logic [31:0] Addr0,
  input  logic [31:0] WData0,
  output logic        Done0,
  output logic        Err0,
  input  logic        Req1,
  input  logic        Write1,
  input  logic [31:0] Addr1,
  input  logic [31:0] WData1,
  output logic        Done1,
  output logic        Err1,
  output logic [31:0] RData,
  output logic        Busy,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemReadData
);

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        win_q, win_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        gnt_any;
  logic        gnt_port;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_bad;

  // Both requesting: the priority pointer decides; otherwise whoever asks wins.
  always_comb begin
    gnt_any   = Req0 | Req1;
    gnt_port  = (Req0 && Req1) ? prio_q : Req1;
    sel_wr    = gnt_port ? Write1 : Write0;
    sel_addr  = gnt_port ? Addr1  : Addr0;
    sel_wdata = gnt_port ? WData1 : WData0;
    sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    win_d   = win_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          win_d  = gnt_port;
          wr_d   = sel_wr;
          err_d  = sel_bad;
          prio_d = ~gnt_port;
          if (sel_bad) begin
            state_d = RESP;
          end else begin
            // Memory-facing address/data only change on real accesses so they hold otherwise.
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        rdata_d = MemReadData;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      prio_q  <= (RR_INIT != 0);
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    Busy         = (state_q != IDLE);
    MemAddress   = addr_q;
    MemWriteData = wdata_q;
    MemRead      = (state_q == ISSUE) && !wr_q;
    MemWrite     = (state_q == ISSUE) && wr_q;
    Done0        = (state_q == RESP) && !win_q;
    Done1        = (state_q == RESP) && win_q;
    Err0         = Done0 && err_q;
    Err1         = Done1 && err_q;
    RData        = ((state_q == RESP) && !wr_q && !err_q) ? rdata_q : 32'h0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table of single accesses plus hand-written
// sequences for contention, back-to-back reads and reset during ISSUE.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Req0 = 1'b0, Write0 = 1'b0, Req1 = 1'b0, Write1 = 1'b0;
  logic [31:0] Addr0 = '0, WData0 = '0, Addr1 = '0, WData1 = '0;
  logic        Done0, Err0, Done1, Err1, Busy, MemRead, MemWrite;
  logic [31:0] RData, MemAddress, MemWriteData, MemReadData;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter #(.MEM_BYTES(65536), .RR_INIT(0)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req0(Req0), .Write0(Write0), .Addr0(Addr0), .WData0(WData0), .Done0(Done0), .Err0(Err0),
    .Req1(Req1), .Write1(Write1), .Addr1(Addr1), .WData1(WData1), .Done1(Done1), .Err1(Err1),
    .RData(RData), .Busy(Busy), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  // Big-endian byte memory model, no reset
  logic [7:0]  mem [0:65535];
  logic [15:0] ma;
  assign ma = MemAddress[15:0];
  assign MemReadData = {mem[ma], mem[ma + 16'd1], mem[ma + 16'd2], mem[ma + 16'd3]};
  always @(posedge Clk) begin
    if (MemWrite) begin
      mem[ma]         <= MemWriteData[31:24];
      mem[ma + 16'd1] <= MemWriteData[23:16];
      mem[ma + 16'd2] <= MemWriteData[15:8];
      mem[ma + 16'd3] <= MemWriteData[7:0];
    end
  end

  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic req, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (port) begin
      Req1 = req; Write1 = wr; Addr1 = addr; WData1 = wd;
    end else begin
      Req0 = req; Write0 = wr; Addr0 = addr; WData0 = wd;
    end
  endtask

  task automatic access(input vec_t v, input string tag);
    int   cyc;
    int   rd_cnt;
    int   wr_cnt;
    logic seen;
    cyc = 0; rd_cnt = 0; wr_cnt = 0; seen = 1'b0;
    @(posedge Clk); #1;
    drive(v.port, 1'b1, v.wr, v.addr, v.wdata);
    while (!seen && cyc < 10) begin
      @(negedge Clk);
      cyc++;
      if (MemRead)  rd_cnt++;
      if (MemWrite) wr_cnt++;
      if (v.port ? Done1 : Done0) begin
        seen = 1'b1;
        check({tag, " latency"}, 32'(cyc), v.exp_err ? 32'd2 : 32'd3);
        check({tag, " err"}, 32'(v.port ? Err1 : Err0), 32'(v.exp_err));
        check({tag, " rdata"}, RData, v.exp_rdata);
        check({tag, " other done"}, 32'(v.port ? Done0 : Done1), 32'd0);
        if (!v.exp_err) check({tag, " memaddr hold"}, MemAddress, v.addr);
      end
    end
    if (!seen) check({tag, " done timeout"}, 32'd0, 32'd1);
    check({tag, " read strobes"}, 32'(rd_cnt), 32'(!v.exp_err && !v.wr));
    check({tag, " write strobes"}, 32'(wr_cnt), 32'(!v.exp_err && v.wr));
    @(posedge Clk); #1;
    drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " done/err"}, {28'h0, Done0, Err0, Done1, Err1}, 32'h0);
    check({tag, " busy/strobes"}, {29'h0, Busy, MemRead, MemWrite}, 32'h0);
    check({tag, " rdata"}, RData, 32'h0);
    check({tag, " memaddr"}, MemAddress, 32'h0);
    check({tag, " memwdata"}, MemWriteData, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ndone;
    int   dport[8];
    int   dcyc[8];
    logic [31:0] ddata[8];
    int   rises;
    int   highs;
    int   cyc;
    int   seen;
    logic prev_rd;

    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0022, 32'hAABB_CCDD, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h1122_3344};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_FFFE, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0001_0000, 32'h5555_5555, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_FFFC, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_FFFC, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0102_0304, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0506_0708, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_0003, 32'h0,         1'b1, 32'h0};

    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_outputs_zero("reset");
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    for (int i = 0; i < 12; i++) access(vecs[i], $sformatf("vec%0d", i));

    check("misaligned left 0x22 intact", 32'(mem[16'h0022]), 32'h33);
    check("big-endian byte0", 32'(mem[16'h0000]), 32'h01);
    check("big-endian byte3", 32'(mem[16'h0003]), 32'h04);

    // Contention after reset: both held, grants must alternate 0,1,0,1 every 3 cycles
    @(posedge Clk); #1 Rst_n = 1'b0;
    @(posedge Clk); #1 Rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      check("never both done", 32'(Done0 & Done1), 32'd0);
      if ((Done0 || Done1) && ndone < 8) begin
        dport[ndone] = Done1 ? 1 : 0;
        dcyc[ndone]  = k;
        ddata[ndone] = RData;
        ndone++;
      end
    end
    @(posedge Clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rr done count", 32'(ndone), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ndone) begin
        check($sformatf("rr grant%0d port", i), 32'(dport[i]), 32'(i % 2));
        check($sformatf("rr grant%0d cycle", i), 32'(dcyc[i]), 32'(3 + 3 * i));
        check($sformatf("rr grant%0d rdata", i), ddata[i], (i % 2) ? 32'h0506_0708 : 32'h0102_0304);
      end
    end

    // Back-to-back reads from port 0: new address presented on the edge ending Done0
    repeat (2) @(posedge Clk);
    #1 drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    rises = 0; highs = 0; cyc = 0; seen = 0; prev_rd = 1'b0;
    while (seen < 2 && cyc < 12) begin
      @(negedge Clk);
      cyc++;
      if (MemRead) highs++;
      if (MemRead && !prev_rd) rises++;
      prev_rd = MemRead;
      if (Done0) begin
        seen++;
        if (seen == 1) begin
          check("b2b first rdata", RData, 32'h0102_0304);
          check("b2b first cycle", 32'(cyc), 32'd3);
          @(posedge Clk); #1 Addr0 = 32'h4;
        end else begin
          check("b2b second rdata", RData, 32'h0506_0708);
          check("b2b second cycle", 32'(cyc), 32'd6);
          @(posedge Clk); #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
    end
    check("b2b done count", 32'(seen), 32'd2);
    check("b2b memread high cycles", 32'(highs), 32'd2);
    check("b2b memread rising edges", 32'(rises), 32'd2);

    // Reset asserted while a write is in ISSUE
    repeat (2) @(posedge Clk);
    #1 drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge Clk);
    check("rst-issue write strobe", 32'(MemWrite), 32'd1);
    @(posedge Clk); #1 Rst_n = 1'b1;
    @(negedge Clk);
    check_outputs_zero("rst-issue after");
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check($sformatf("rst-issue no done %0d", k), 32'(Done0 | Done1), 32'd0);
    end
    check("rst-issue mem byte", 32'(mem[16'h0040]), 32'h12);
    access('{1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h1234_5678}, "rst-issue readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
